// File: rtl/dmem_mmio_responder_if.sv
// Bundles the data-memory bus and TX stream between processor/sink and the MMIO responder.
// No logic; signal timing is set by the responder (1-cycle registered reads).
// master drives address/data/wren/tx_ready, slave returns hit/read data and the TX stream.
interface dmem_mmio_responder_if;
    logic [11:0] address_dmem;  // word address from processor
    logic [31:0] data;          // store data from processor
    logic        wren;          // store enable
    logic        mmio_hit;      // registered: previous address was in the window
    logic [31:0] q_mmio;        // registered read data
    logic        tx_valid;      // FIFO head valid
    logic [31:0] tx_data;       // FIFO head word
    logic        tx_ready;      // sink accepts head

    modport master (
        output address_dmem, data, wren, tx_ready,
        input  mmio_hit, q_mmio, tx_valid, tx_data
    );

    modport slave (
        input  address_dmem, data, wren, tx_ready,
        output mmio_hit, q_mmio, tx_valid, tx_data
    );
endinterface

// File: rtl/dmem_mmio_responder.sv
// MMIO responder on dmem: TX FIFO, status, free-running cycle counter, scratch register.
// Reads return one cycle after the address (matches dmem syncram); TX head is combinational.
// TX stream is valid/ready; pushes into a full FIFO without a same-cycle pop are dropped and flag ovf.
// Ports: clock, reset (async active-low), bus (slave modport: address_dmem/data/wren in,
//        mmio_hit/q_mmio out, tx_valid/tx_data out, tx_ready in).
module dmem_mmio_responder #(
    parameter int          DEPTH = 8,
    parameter int          CNT_W = 4,
    parameter logic [11:0] BASE  = 12'hFF0
) (
    input  logic                        clock,
    input  logic                        reset,
    dmem_mmio_responder_if.slave        bus
);
    localparam int              PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [31:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [31:0]      cycle_q, cycle_d;
    logic [31:0]      scratch_q, scratch_d;
    logic             hit_q, hit_d;
    logic [31:0]      rdata_q, rdata_d;

    logic        sel;
    logic [3:0]  offset;
    logic        wr_sel;
    logic        empty, full;
    logic        pop, push_req, push_ok;
    logic [3:0]  count4;
    logic [31:0] status;
    logic [31:0] rd_mux;

    always_comb begin
        sel      = (bus.address_dmem[11:4] == BASE[11:4]);
        offset   = bus.address_dmem[3:0];
        wr_sel   = bus.wren & sel;
        empty    = (count_q == '0);
        full     = (count_q == DEPTH_C);
        pop      = ~empty & bus.tx_ready;
        push_req = wr_sel & (offset == 4'd0);
        // A full FIFO still takes a push when the head leaves on the same edge.
        push_ok  = push_req & (~full | pop);

        count4 = 4'(count_q);
        status = {25'b0, ovf_q, full, empty, count4};

        rd_mux = 32'h0;
        case (offset)
            4'd1:    rd_mux = status;
            4'd2:    rd_mux = cycle_q;
            4'd3:    rd_mux = scratch_q;
            default: rd_mux = 32'h0;
        endcase

        hit_d   = sel;
        rdata_d = sel ? rd_mux : 32'h0;

        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);

        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Clear first so a dropped push in the same cycle still leaves ovf set.
        ovf_d = ovf_q;
        if (wr_sel && offset == 4'd1 && bus.data[6]) ovf_d = 1'b0;
        if (push_req && !push_ok)                    ovf_d = 1'b1;

        cycle_d = cycle_q + 32'd1;
        if (wr_sel && offset == 4'd2) cycle_d = bus.data;

        scratch_d = scratch_q;
        if (wr_sel && offset == 4'd3) scratch_d = bus.data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            cycle_q   <= 32'h0;
            scratch_q <= 32'h0;
            hit_q     <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            cycle_q   <= cycle_d;
            scratch_q <= scratch_d;
            hit_q     <= hit_d;
            rdata_q   <= rdata_d;
        end
    end

    // Storage needs no reset: the head is masked by count, which is reset.
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= bus.data;
    end

    assign bus.mmio_hit = hit_q;
    assign bus.q_mmio   = rdata_q;
    assign bus.tx_valid = ~empty;
    assign bus.tx_data  = empty ? 32'h0 : mem_q[rd_ptr_q];
endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
- Responder on the processor's data-memory bus (address_dmem/data/wren). It answers a 16-word memory-mapped I/O window at the top of the 12-bit dmem space, next to dmem in the skeleton.
- Provides a TX FIFO drained over a valid/ready stream, a status register, a free-running cycle counter and a scratch register.
- Read data is registered, matching the one-cycle dmem syncram latency. The top level muxes q_mmio over q_dmem when the registered hit is set.

Parameters:
- DEPTH, 8: TX FIFO entries; power of two, minimum 2.
- CNT_W, 4: width of the FIFO occupancy count; must hold DEPTH.
- BASE, 12'hFF0: window base; low 4 bits must be 0.

Ports:
- clock  in  1: single clock, rising edge; dmem_clock domain.
- reset  in  1: asynchronous, active-low reset; 0 = reset asserted.
- address_dmem  in  12: word address from processor.
- data  in  32: store data from processor.
- wren  in  1: store enable from processor.
- mmio_hit  out  1: registered; 1 = the previous-cycle address was inside the window.
- q_mmio  out  32: registered read data for the previous-cycle address.
- tx_valid  out  1: FIFO head is valid.
- tx_data  out  32: FIFO head word.
- tx_ready  in  1: sink accepts head this cycle.

Behaviour:
- Reset (reset=0, async): FIFO empty, rd/wr pointers 0, count 0, overflow 0, cycle 0, scratch 0. Outputs: mmio_hit=0, q_mmio=0, tx_valid=0, tx_data=0.
- Decode: sel = (address_dmem[11:4] == BASE[11:4]); offset = address_dmem[3:0].
- Register map (offset: read / write):
  - 0 TXDATA: read 0 / push data.
  - 1 STATUS: read {25'b0, ovf, full, empty, count}; count is zero-extended to 4 bits / if data[6]=1, clear ovf.
  - 2 CYCLE: read counter / load counter with data.
  - 3 SCRATCH: read value / write value.
  - 4-15: read 0 / write ignored.
- Read path: on each edge, mmio_hit <= sel and q_mmio <= (sel ? mux(offset) : 0).
  - Latency is exactly 1 cycle.
  - Values are sampled pre-edge, so a same-cycle write or push is not visible in that read.
- Writes act only when wren=1 and sel=1. When sel=0, all state is unchanged except the counter increment and FIFO pop.
- FIFO:
  - push_req = wren & sel & offset==0; pop = tx_valid & tx_ready.
  - Push is accepted if count<DEPTH, or if count==DEPTH and pop occurs in the same cycle.
  - A push that is not accepted drops the word and sets ovf (sticky). If an STATUS clear and a set could occur in the same cycle, set wins; they cannot coincide because they use different offsets.
  - count is updated by +push -pop; simultaneous push and pop leaves count unchanged.
  - There is no bypass: a push into an empty FIFO raises tx_valid on the following cycle.
  - tx_valid = (count != 0). tx_data = mem[rd_ptr], and is 0 when empty.
  - Pointers wrap modulo DEPTH.
  - empty = (count==0); full = (count==DEPTH).
- Cycle counter: increments by 1 every clock and wraps 0xFFFFFFFF -> 0. A CYCLE write takes priority: counter <= data on that edge, with no increment that cycle.
- Stream rule: tx_data and tx_valid hold stable until a pop. tx_ready while tx_valid=0 has no effect.
- Reset mid-operation: FIFO contents are discarded and tx_valid drops immediately (async). No pop is reported.

Test Plan:
- Reset low, then release; read STATUS (address 0xFF1) -> the next cycle gives mmio_hit=1, q_mmio=0x00000010 (empty=1, count=0).
- Push 0xA5A5A5A5 to 0xFF0 with tx_ready=0 -> tx_valid=1 one cycle later, tx_data=0xA5A5A5A5. Read STATUS -> 0x00000001.
- Push 9 words 1..9 with tx_ready=0 -> STATUS=0x00000068 (ovf, full, count=8). Drain with tx_ready=1 -> tx_data sequence 1..8, then tx_valid=0. Write 0x40 to 0xFF1 -> STATUS=0x00000010.
- With the FIFO full, push 0x55 and pop in the same cycle -> count stays 8, ovf=0, and 0x55 is emitted last.
- Write 0xFFFFFFFE to 0xFF2, then read 0xFF2 two cycles after the write -> q_mmio=0xFFFFFFFF. The following read returns 0x00000000 (wrap).
- Write 0x1234 to 0xFF3 and read it back -> 0x00001234. Read 0x100 -> mmio_hit=0, q_mmio=0. Assert reset with 3 entries queued -> tx_valid=0 asynchronously and STATUS=0x10 after release.
